// File: rtl/simon_playback.sv
// simon_playback: plays back a stored colour sequence (entries 0..level) from
// an external 8x2 memory. Each colour is shown for ON_CYCLES cycles and then
// blanked for OFF_CYCLES cycles. A one-cycle done pulse marks the end.
// Optional feature: define SIMON_PLAYBACK_ABORT_EN to add the abort input,
// which returns any active playback to IDLE without a done pulse.
module simon_playback #(
  parameter int ON_CYCLES  = 25000000,
  parameter int OFF_CYCLES = 12500000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [2:0] level,
  output logic [2:0] mem_addr,
  input  logic [1:0] mem_data,
  output logic       mem_we,
  output logic [1:0] color,
  output logic       show,
  output logic       busy,
  output logic       done
`ifdef SIMON_PLAYBACK_ABORT_EN
  ,
  input  logic       abort
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SHOW  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Timer reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [25:0] ON_LOAD  = 26'(ON_CYCLES)  - 26'd1;
  localparam logic [25:0] OFF_LOAD = 26'(OFF_CYCLES) - 26'd1;

  state_t      state_r;
  state_t      fsm_next_s;
  state_t      state_next_s;
  logic [2:0]  index_r;
  logic [2:0]  index_next_s;
  logic [2:0]  lvl_r;          // level latched at start (lvl_q)
  logic [2:0]  lvl_next_s;
  logic [25:0] timer_r;
  logic [25:0] timer_next_s;
  logic [1:0]  color_r;
  logic [1:0]  color_next_s;
  logic        show_r;
  logic        busy_r;
  logic        done_r;
  logic        abort_hit_s;

  // Normal playback sequencing and datapath next-values.
  always_comb begin
    fsm_next_s   = state_r;
    index_next_s = index_r;
    lvl_next_s   = lvl_r;
    timer_next_s = timer_r;
    color_next_s = color_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          lvl_next_s   = level;
          index_next_s = 3'd0;
          fsm_next_s   = ST_FETCH;
        end else begin
          fsm_next_s   = ST_IDLE;
        end
      end
      ST_FETCH: begin
        color_next_s = mem_data;
        timer_next_s = ON_LOAD;
        fsm_next_s   = ST_SHOW;
      end
      ST_SHOW: begin
        if (timer_r == 26'd0) begin
          timer_next_s = OFF_LOAD;
          fsm_next_s   = ST_GAP;
        end else begin
          timer_next_s = timer_r - 26'd1;
        end
      end
      ST_GAP: begin
        if (timer_r == 26'd0) begin
          // The last entry exits to DONE, so the index never wraps.
          if (index_r == lvl_r) begin
            fsm_next_s   = ST_DONE;
          end else begin
            index_next_s = index_r + 3'd1;
            fsm_next_s   = ST_FETCH;
          end
        end else begin
          timer_next_s = timer_r - 26'd1;
        end
      end
      ST_DONE: begin
        fsm_next_s = ST_IDLE;
      end
      default: begin
        fsm_next_s = ST_IDLE;
      end
    endcase
  end

`ifdef SIMON_PLAYBACK_ABORT_EN
  assign abort_hit_s = abort && (state_r != ST_IDLE);
`else
  assign abort_hit_s = 1'b0;
`endif

  // Abort overrides every other transition; without the feature it never fires.
  always_comb begin
    state_next_s = fsm_next_s;
    if (abort_hit_s) begin
      state_next_s = ST_IDLE;
    end else begin
      state_next_s = fsm_next_s;
    end
  end

  // State, datapath and registered status outputs; outputs track the next state
  // so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      index_r <= 3'd0;
      lvl_r   <= 3'd0;
      timer_r <= 26'd0;
      color_r <= 2'd0;
      show_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      index_r <= index_next_s;
      lvl_r   <= lvl_next_s;
      timer_r <= timer_next_s;
      color_r <= color_next_s;
      show_r  <= (state_next_s == ST_SHOW);
      busy_r  <= (state_next_s != ST_IDLE);
      done_r  <= (state_next_s == ST_DONE);
    end
  end

  assign mem_addr = index_r;
  assign mem_we   = 1'b0;
  assign color    = color_r;
  assign show     = show_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_simon_playback.sv
// Bench for simon_playback with ON_CYCLES=3, OFF_CYCLES=2. Expected outputs for
// every cycle of a playback come from the timing rules: each entry occupies
// 1+ON+OFF cycles (fetch, show, gap) and a final done cycle follows.
module tb_simon_playback;

  localparam int ON  = 3;
  localparam int OFF = 2;
  localparam int P   = 1 + ON + OFF;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [2:0] level = 3'd0;
  logic [2:0] mem_addr;
  logic [1:0] mem_data;
  logic       mem_we;
  logic [1:0] color;
  logic       show;
  logic       busy;
  logic       done;
`ifdef SIMON_PLAYBACK_ABORT_EN
  logic       abort = 1'b0;
`endif

  logic [1:0] mem [8];
  logic [1:0] prev_color = 2'd0;
  int         checks = 0;
  int         errors = 0;

  assign mem_data = mem[mem_addr];

  simon_playback #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
    .clk(clk), .resetn(resetn), .start(start), .level(level),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
    .color(color), .show(show), .busy(busy), .done(done)
`ifdef SIMON_PLAYBACK_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int n, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, n, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic with_zero);
    chk({tag, "_busy"}, 0, {7'd0, busy}, 8'd0);
    chk({tag, "_show"}, 0, {7'd0, show}, 8'd0);
    chk({tag, "_done"}, 0, {7'd0, done}, 8'd0);
    chk({tag, "_we"},   0, {7'd0, mem_we}, 8'd0);
    if (with_zero) begin
      chk({tag, "_color"}, 0, {6'd0, color}, 8'd0);
      chk({tag, "_addr"},  0, {5'd0, mem_addr}, 8'd0);
    end
  endtask

  // Plays level L starting at the current negedge. dist_n: cycle at which a
  // stray start (with level 5) is raised for one cycle. cut_n: cycle after
  // which reset (kind 0) or abort (kind 1) is applied. extra: IDLE cycles
  // checked after the done cycle.
  task automatic play(input int L, input int dist_n, input int cut_n, input int kind, input int extra);
    int B;
    int e;
    int p;
    logic       eb, es, ed;
    logic [2:0] ea;
    logic [1:0] ec;
    B = (L + 1) * P + 1;
    start = 1'b1;
    level = 3'(L);
    for (int n = 1; n <= B + extra; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        level = 3'($urandom_range(0, 7));
      end
      if (n == dist_n + 1) start = 1'b0;
      if (n < B) begin
        e  = (n - 1) / P;
        p  = (n - 1) % P;
        eb = 1'b1;
        ed = 1'b0;
        es = (p >= 1) && (p <= ON);
        ea = 3'(e);
        ec = (p != 0) ? mem[e] : ((e == 0) ? prev_color : mem[e - 1]);
      end else begin
        eb = (n == B);
        ed = (n == B);
        es = 1'b0;
        ea = 3'(L);
        ec = mem[L];
      end
      chk("busy",  n, {7'd0, busy}, {7'd0, eb});
      chk("show",  n, {7'd0, show}, {7'd0, es});
      chk("done",  n, {7'd0, done}, {7'd0, ed});
      chk("addr",  n, {5'd0, mem_addr}, {5'd0, ea});
      chk("color", n, {6'd0, color}, {6'd0, ec});
      chk("we",    n, {7'd0, mem_we}, 8'd0);
      if (n == dist_n) begin
        start = 1'b1;
        level = 3'd5;
      end
      if (n == cut_n) begin
        if (kind == 0) resetn = 1'b0;
`ifdef SIMON_PLAYBACK_ABORT_EN
        if (kind == 1) abort = 1'b1;
`endif
        @(negedge clk);
        resetn = 1'b1;
`ifdef SIMON_PLAYBACK_ABORT_EN
        abort = 1'b0;
`endif
        chk_idle("cut", (kind == 0));
        prev_color = (kind == 0) ? 2'd0 : ec;
        repeat (3) begin
          @(negedge clk);
          chk_idle("after_cut", 1'b0);
        end
        return;
      end
    end
    prev_color = mem[L];
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 2'($urandom_range(0, 3));
    repeat (2) @(negedge clk);
    chk_idle("reset", 1'b1);
    resetn = 1'b1;
    @(negedge clk);
    chk_idle("post_reset", 1'b1);

    // Three-colour sequence 2,1,3.
    mem[0] = 2'd2; mem[1] = 2'd1; mem[2] = 2'd3;
    play(2, 0, 0, 0, 3);

    // Single colour, address stays 0.
    mem[0] = 2'd1;
    play(0, 0, 0, 0, 3);

    // Full eight-entry sequence, index stops at 7.
    mem[0] = 2'd0; mem[1] = 2'd1; mem[2] = 2'd2; mem[3] = 2'd3;
    mem[4] = 2'd3; mem[5] = 2'd2; mem[6] = 2'd1; mem[7] = 2'd0;
    play(7, 0, 0, 0, 3);

    // Stray start and level change during SHOW of a two-colour playback.
    for (int i = 0; i < 8; i++) mem[i] = 2'($urandom_range(0, 3));
    play(1, 3, 0, 0, 3);

    // Start held in DONE is ignored; start in the following IDLE is accepted.
    play(2, 19, 0, 0, 1);
    play(1, 0, 0, 0, 3);

    // Reset during the second GAP, then a fresh playback from address 0.
    play(3, 0, P + ON + 2, 0, 0);
    play(2, 0, 0, 0, 3);

`ifdef SIMON_PLAYBACK_ABORT_EN
    // Abort during SHOW of entry 1, then normal playback resumes.
    play(3, 0, P + 2, 1, 0);
    play(1, 0, 0, 0, 3);
`endif

    // Randomized playbacks.
    repeat (6) begin
      for (int i = 0; i < 8; i++) mem[i] = 2'($urandom_range(0, 3));
      play($urandom_range(0, 7), 0, 0, 0, 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
